mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: max consecutive data wins while fetch waits.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_W: instruction fetch request and word address.
REQ-006 SHALL have ports if_gnt out 1, if_valid out 1, if_rdata out 32: fetch accept pulse, completion pulse, fetched word.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in 32, d_be in 4: data request, write enable, address, store data, byte enables.
REQ-008 SHALL have ports d_gnt out 1, d_valid out 1, d_rdata out 32: data accept pulse, completion pulse, load word.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_be out 4: unified memory port.
REQ-010 SHALL have ports mem_ready in 1, mem_rdata in 32: memory completion and read data, valid while mem_ready=1.
REQ-011 SHALL have port stall, output, 1: core must hold PC and pipeline state.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-013 In IDLE, SHALL accept at most one request per cycle and pulse the matching gnt for exactly that cycle.
REQ-014 On simultaneous if_req and d_req, data SHALL win unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-015 starve_cnt SHALL increment, saturating at STARVE_LIMIT, when data wins while if_req=1, and clear to 0 when fetch is granted.
REQ-016 On accept, SHALL latch addr/we/wdata/be into request registers; fetch uses we=0, be=4'b1111.
REQ-017 In BUSY_*, mem_req SHALL be 1 and mem_* SHALL drive latched fields unchanged until mem_ready=1.
REQ-018 In IDLE, mem_req SHALL be 0 and mem_we SHALL be 0.
REQ-019 On mem_ready=1 in BUSY_*, SHALL register mem_rdata into the owner's rdata, pulse the owner's valid next cycle, and return to IDLE.
REQ-020 A new request SHALL be accepted in the same cycle its predecessor's valid pulses; minimum accept-to-valid latency is 2 cycles.
REQ-021 For stores, d_valid SHALL pulse on completion and d_rdata SHALL hold its previous value.
REQ-022 if_rdata/d_rdata SHALL hold their value until the next completion for that owner.
REQ-023 mem_ready SHALL be ignored in IDLE.
REQ-024 stall SHALL be 1 when state != IDLE, or when if_req and d_req are both 1, or on any cycle where a valid pulse is still pending; otherwise 0.
REQ-025 Requests deasserted before grant SHALL be dropped without memory access.

Reset
REQ-026 On reset=0, SHALL asynchronously force state=IDLE, starve_cnt=0, and all outputs to 0, including rdata and mem_* fields.
REQ-027 Reset mid-transaction SHALL abort it with no valid pulse; mem_req SHALL drop in the reset cycle.
REQ-028 The first accept after reset release SHALL occur no earlier than the first rising edge with reset=1.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum and default STARVE_LIMIT.
REQ-030 Sub-module arb_req_latch SHALL hold the captured addr/we/wdata/be register; arbitration and FSM SHALL remain in mem_port_arbiter.

Verification
REQ-031 if_req=1, addr=0x100, mem_ready=1 on 1st BUSY cycle -> if_gnt cycle 0, mem_addr=0x100 cycle 1, if_valid cycle 2 with if_rdata=mem_rdata.
REQ-032 if_req and d_req both held at 1 with STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I.
REQ-033 Store d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=0011, mem_ready after 4 cycles -> mem fields stable 4 cycles, d_valid pulse, d_rdata unchanged.
REQ-034 Reset low during BUSY_D -> mem_req=0 immediately, no d_valid, IDLE after release.
REQ-035 mem_ready=1 while IDLE and no request -> no valid pulse, mem_req=0, stall=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned STARVE_LIMIT_DEF = 3;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned BE_W             = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Captured request attributes; the address travels separately since its width is a parameter.
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_attr_t;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 32'd1) ? 32'd1 : 32'($clog2(limit + 32'd1));
    endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Holds the address and attributes of the granted request for the whole memory access.
module arb_req_latch
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              retire,
    input  logic [ADDR_W-1:0] load_addr,
    input  req_attr_t         load_attr,
    output logic [ADDR_W-1:0] addr,
    output req_attr_t         attr
);

    // Write enable is dropped on retire so the port never shows a write while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
            attr <= '0;
        end else if (load) begin
            addr <= load_addr;
            attr <= load_attr;
        end else if (retire) begin
            attr.we <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port, data first with a
// starvation guard that periodically forces a fetch through.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall
);

    localparam int unsigned        CNT_W      = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]   STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              idle, fetch_win, data_win, accept, done;
    logic              mem_req_d, if_valid_d, d_valid_d;
    logic [DATA_W-1:0] if_rdata_d, d_rdata_d;
    logic [ADDR_W-1:0] nxt_addr, lat_addr;
    req_attr_t         nxt_attr, lat_attr;

    // Arbitration, next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_rdata_d = if_rdata;
        d_rdata_d  = d_rdata;
        nxt_attr   = '0;

        idle      = (state_q == IDLE);
        fetch_win = if_req & (~d_req | (starve_q == STARVE_MAX));
        data_win  = d_req & ~fetch_win;
        accept    = idle & (fetch_win | data_win);
        done      = ~idle & mem_ready;

        nxt_addr = fetch_win ? if_addr : d_addr;
        if (fetch_win) begin
            nxt_attr.we    = 1'b0;
            nxt_attr.wdata = '0;
            nxt_attr.be    = '1;
        end else begin
            nxt_attr.we    = d_we;
            nxt_attr.wdata = d_wdata;
            nxt_attr.be    = d_be;
        end

        case (state_q)
            IDLE: begin
                if (fetch_win) begin
                    state_d  = BUSY_I;
                    starve_d = '0;
                end else if (data_win) begin
                    state_d = BUSY_D;
                    if (if_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    d_valid_d = 1'b1;
                    if (!lat_attr.we) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        mem_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            mem_req  <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            mem_req  <= mem_req_d;
            if_valid <= if_valid_d;
            d_valid  <= d_valid_d;
            if_rdata <= if_rdata_d;
            d_rdata  <= d_rdata_d;
        end
    end

    arb_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_req_latch (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .retire    (done),
        .load_addr (nxt_addr),
        .load_attr (nxt_attr),
        .addr      (lat_addr),
        .attr      (lat_attr)
    );

    assign mem_addr  = lat_addr;
    assign mem_we    = lat_attr.we;
    assign mem_wdata = lat_attr.wdata;
    assign mem_be    = lat_attr.be;

    // Grants and stall are same-cycle handshakes, held low while reset is asserted.
    assign if_gnt = reset & idle & fetch_win;
    assign d_gnt  = reset & idle & data_win;
    assign stall  = reset & (~idle | (if_req & d_req) | if_valid | d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and random traffic
// checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 3;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_valid;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          d_req, d_we, d_gnt, d_valid;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic [3:0]    d_be;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;
    logic          stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                         input logic mr, input logic [31:0] mrd);
        if_req = ir;  if_addr = ia;
        d_req = dr;   d_we = dw; d_addr = da; d_wdata = dwd; d_be = dbe;
        mem_ready = mr; mem_rdata = mrd;
    endtask

    // ---------------- transaction-level reference model ----------------
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_starve;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    logic [3:0]  m_be;
    logic        m_we, m_if_v, m_d_v;

    task automatic model_reset();
        m_owner = 0; m_starve = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0;
        m_if_rdata = '0; m_d_rdata = '0; m_if_v = 1'b0; m_d_v = 1'b0;
    endtask

    task automatic model_check();
        logic idle, fw;
        idle = (m_owner == 0);
        fw   = if_req && (!d_req || (m_starve == int'(LIMIT)));
        chk("rnd_if_gnt",  32'(if_gnt),  32'(idle && fw));
        chk("rnd_d_gnt",   32'(d_gnt),   32'(idle && d_req && !fw));
        chk("rnd_mem_req", 32'(mem_req), 32'(!idle));
        chk("rnd_mem_we",  32'(mem_we),  32'(!idle && m_we));
        if (!idle) begin
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_be",   32'(mem_be), 32'(m_be));
            if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
        end
        chk("rnd_if_valid", 32'(if_valid), 32'(m_if_v));
        chk("rnd_d_valid",  32'(d_valid),  32'(m_d_v));
        chk("rnd_if_rdata", if_rdata, m_if_rdata);
        chk("rnd_d_rdata",  d_rdata,  m_d_rdata);
        chk("rnd_stall", 32'(stall), 32'(!idle || (if_req && d_req) || m_if_v || m_d_v));
    endtask

    task automatic model_update();
        logic fw;
        fw = if_req && (!d_req || (m_starve == int'(LIMIT)));
        m_if_v = 1'b0;
        m_d_v  = 1'b0;
        if (m_owner != 0) begin
            if (mem_ready) begin
                if (m_owner == 1) begin
                    m_if_rdata = mem_rdata; m_if_v = 1'b1;
                end else begin
                    if (!m_we) m_d_rdata = mem_rdata;
                    m_d_v = 1'b1;
                end
                m_owner = 0;
            end
        end else if (fw) begin
            m_owner = 1; m_addr = if_addr; m_we = 1'b0; m_be = 4'hF; m_starve = 0;
        end else if (d_req) begin
            m_owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_be = d_be;
            if (if_req && (m_starve < int'(LIMIT))) m_starve++;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int ir; logic [31:0] ia; int dr; int dw; logic [31:0] da; logic [31:0] dwd; int dbe;
        int mr; logic [31:0] mrd;
        int gi; int gd; int mq; int mw; logic [31:0] ma; logic [31:0] mwd; int mbe;
        int vi; int vd; logic [31:0] ri; logic [31:0] rd; int st;
    } vec_t;

    vec_t tbl[16];
    int   ord[8];
    int   exp_ord[8];
    int   ngr;

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_if_gnt",   32'(if_gnt),   0);
        chk("rst_d_gnt",    32'(d_gnt),    0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_d_valid",  32'(d_valid),  0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata",  d_rdata,  0);
        chk("rst_mem_req",  32'(mem_req), 0);
        chk("rst_mem_we",   32'(mem_we),  0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be",   32'(mem_be), 0);
        chk("rst_stall",    32'(stall),  0);
        reset_dut();

        // stimulus: ir ia dr dw da dwd dbe mr mrd | expect: gi gd mq mw ma mwd mbe vi vd ri rd st
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 1, 'h55,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 'h100, 0, 0, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D,  0, 0, 1, 0, 'h100, 0, 'hF, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 1, 0, 'hCAFEF00D, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 'hCAFEF00D, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 'h2000, 0, 'hF, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 0, 'hCAFEF00D, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 'h2000, 0, 'hF, 0, 0, 'hCAFEF00D, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 'h12345678,  0, 0, 1, 0, 'h2000, 0, 'hF, 0, 0, 'hCAFEF00D, 0, 1};
        tbl[8]  = '{0, 0, 1, 1, 'h2004, 'hDEADBEEF, 'h3, 0, 0,
                    0, 1, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D, 'h12345678, 1};
        for (int i = 9; i <= 12; i++)
            tbl[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                       0, 0, 1, 1, 'h2004, 'hDEADBEEF, 'h3, 0, 0, 'hCAFEF00D, 'h12345678, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 'hFFFF0000,
                    0, 0, 1, 1, 'h2004, 'hDEADBEEF, 'h3, 0, 0, 'hCAFEF00D, 'h12345678, 1};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D, 'h12345678, 1};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 'h77,        0, 0, 0, 0, 0, 0, 0, 0, 0, 'hCAFEF00D, 'h12345678, 0};

        for (int i = 0; i < 16; i++) begin
            drive(1'(tbl[i].ir), tbl[i].ia, 1'(tbl[i].dr), 1'(tbl[i].dw), tbl[i].da, tbl[i].dwd,
                  4'(tbl[i].dbe), 1'(tbl[i].mr), tbl[i].mrd);
            @(negedge clk);
            chk($sformatf("vec%0d_if_gnt", i),   32'(if_gnt),   32'(tbl[i].gi));
            chk($sformatf("vec%0d_d_gnt", i),    32'(d_gnt),    32'(tbl[i].gd));
            chk($sformatf("vec%0d_mem_req", i),  32'(mem_req),  32'(tbl[i].mq));
            chk($sformatf("vec%0d_mem_we", i),   32'(mem_we),   32'(tbl[i].mw));
            if (tbl[i].mq != 0) begin
                chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].ma);
                chk($sformatf("vec%0d_mem_be", i),   32'(mem_be), 32'(tbl[i].mbe));
            end
            if (tbl[i].mw != 0) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, tbl[i].mwd);
            chk($sformatf("vec%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].vi));
            chk($sformatf("vec%0d_d_valid", i),  32'(d_valid),  32'(tbl[i].vd));
            chk($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].ri);
            chk($sformatf("vec%0d_d_rdata", i),  d_rdata,  tbl[i].rd);
            chk($sformatf("vec%0d_stall", i),    32'(stall),    32'(tbl[i].st));
            @(posedge clk);
            #1;
        end

        // Both requesters held: data wins LIMIT times, then fetch gets one slot.
        reset_dut();
        exp_ord = '{0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) ord[i] = -1;
        ngr = 0;
        drive(1, 'h400, 1, 0, 'h5000, 0, 4'hF, 1, 'h0BAD0BAD);
        for (int c = 0; c < 40 && ngr < 8; c++) begin
            @(negedge clk);
            if (if_gnt) begin
                ord[ngr] = 1; ngr++;
            end else if (d_gnt) begin
                ord[ngr] = 0; ngr++;
            end
            @(posedge clk);
            #1;
        end
        chk("starve_grant_count", 32'(ngr), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("starve_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));

        // Reset during a data access aborts it without a completion.
        reset_dut();
        drive(0, 0, 1, 0, 'h3000, 0, 4'hF, 0, 0);
        @(negedge clk);
        chk("abort_d_gnt", 32'(d_gnt), 1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("abort_busy_mem_req", 32'(mem_req), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_mem_req_drop", 32'(mem_req), 0);
        chk("abort_stall", 32'(stall), 0);
        drive(1, 'h40, 1, 0, 'h3000, 0, 4'hF, 1, 'h99);
        #1;
        chk("inreset_if_gnt", 32'(if_gnt), 0);
        chk("inreset_d_gnt",  32'(d_gnt),  0);
        chk("inreset_stall",  32'(stall),  0);
        @(posedge clk);
        #1;
        chk("inreset_d_valid", 32'(d_valid), 0);
        chk("inreset_mem_req", 32'(mem_req), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 'h99);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_abort%0d_d_valid", c), 32'(d_valid), 0);
            chk($sformatf("post_abort%0d_mem_req", c), 32'(mem_req), 0);
            chk($sformatf("post_abort%0d_stall", c),   32'(stall),   0);
        end

        // A request held across reset release is first accepted at the first edge out of reset.
        reset = 1'b0;
        drive(0, 0, 1, 0, 'h3100, 0, 4'hF, 0, 0);
        @(posedge clk);
        #1;
        chk("hold_rst_d_gnt",   32'(d_gnt),   0);
        chk("hold_rst_mem_req", 32'(mem_req), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_d_gnt", 32'(d_gnt), 1);
        @(posedge clk);
        #1;
        chk("release_mem_req",  32'(mem_req),  1);
        chk("release_mem_addr", mem_addr, 'h3100);

        // Random traffic against the model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                  1'($urandom_range(0, 99) < 40), $urandom);
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
